// File: rtl/shared_reg_arb.sv
// Round-robin arbiter in front of a bank of enable-flop configuration registers.
// Optional owner lock enabled by defining SHARED_REG_ARB_LOCK_EN.
module shared_reg_arb #(
    parameter int REQ_NUM    = 4,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 3
) (
    input  logic                                   clk_i,
    input  logic                                   rst_n_i,
    input  logic [REQ_NUM-1:0]                     req_i,
    input  logic [REQ_NUM-1:0]                     we_i,
    input  logic [REQ_NUM*ADDR_WIDTH-1:0]          addr_i,
    input  logic [REQ_NUM*DATA_WIDTH-1:0]          wdata_i,
`ifdef SHARED_REG_ARB_LOCK_EN
    input  logic [REQ_NUM-1:0]                     lock_i,
    output logic [0:0]                             dbg_lock_state_o,
    output logic [$clog2(REQ_NUM)-1:0]             dbg_owner_o,
`endif
    output logic [REQ_NUM-1:0]                     gnt_o,
    output logic [REQ_NUM-1:0]                     rvalid_o,
    output logic [DATA_WIDTH-1:0]                  rdata_o,
    output logic [(2**ADDR_WIDTH)*DATA_WIDTH-1:0]  reg_o
);
    localparam int REG_NUM = 2**ADDR_WIDTH;
    localparam int PTR_W   = $clog2(REQ_NUM);

    // Handshake: req_i[k] is a valid held until granted; gnt_o[k] is the ready.
    // An access transfers at the clock edge where req_i[k] & gnt_o[k] is high.

    logic [PTR_W-1:0]      ptr_q, ptr_d, winner, next_ptr;
    logic                  found;
    logic [REQ_NUM-1:0]    rvalid_q, rvalid_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [DATA_WIDTH-1:0] bank_q [REG_NUM];
    logic [DATA_WIDTH-1:0] bank_d;
    logic [REG_NUM-1:0]    bank_en;
    logic                  sel_we;
    logic [ADDR_WIDTH-1:0] sel_addr;

`ifdef SHARED_REG_ARB_LOCK_EN
    localparam logic [0:0] ST_UNLOCKED = 1'b0;
    localparam logic [0:0] ST_LOCKED   = 1'b1;
    logic [0:0]       state_q, state_d;
    logic [PTR_W-1:0] owner_q, owner_d;
`endif

    always_comb begin
        gnt_o  = '0;
        winner = ptr_q;
        found  = 1'b0;
        for (int i = 0; i < REQ_NUM; i++) begin
            int               idx;
            logic [PTR_W-1:0] cand;
            idx = int'(ptr_q) + i;
            if (idx >= REQ_NUM) idx = idx - REQ_NUM;
            cand = PTR_W'(idx);
            if (!found && req_i[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
`ifdef SHARED_REG_ARB_LOCK_EN
        // A locked bank serves only its owner regardless of the pointer.
        if (state_q == ST_LOCKED) begin
            winner = owner_q;
            found  = req_i[owner_q];
        end
`endif
        if (found) gnt_o[winner] = 1'b1;
    end

    always_comb begin
        sel_we   = we_i[winner];
        sel_addr = addr_i[int'(winner)*ADDR_WIDTH +: ADDR_WIDTH];
        bank_d   = wdata_i[int'(winner)*DATA_WIDTH +: DATA_WIDTH];
        next_ptr = (int'(winner) == REQ_NUM-1) ? '0 : winner + PTR_W'(1);
        ptr_d    = found ? next_ptr : ptr_q;
        rvalid_d = '0;
        rdata_d  = rdata_q;
        bank_en  = '0;
        if (found && sel_we) bank_en[sel_addr] = 1'b1;
        if (found && !sel_we) begin
            rvalid_d = gnt_o;
            rdata_d  = bank_q[sel_addr];
        end
`ifdef SHARED_REG_ARB_LOCK_EN
        state_d = state_q;
        owner_d = owner_q;
        if (found) begin
            if (state_q == ST_LOCKED) begin
                ptr_d = ptr_q;
                if (!lock_i[winner]) begin
                    state_d = ST_UNLOCKED;
                    ptr_d   = next_ptr;
                end
            end else if (lock_i[winner]) begin
                state_d = ST_LOCKED;
                owner_d = winner;
            end
        end
`endif
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            ptr_q    <= '0;
            rvalid_q <= '0;
            rdata_q  <= '0;
            for (int r = 0; r < REG_NUM; r++) bank_q[r] <= '0;
`ifdef SHARED_REG_ARB_LOCK_EN
            state_q  <= ST_UNLOCKED;
            owner_q  <= '0;
`endif
        end else begin
            ptr_q    <= ptr_d;
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
            for (int r = 0; r < REG_NUM; r++) begin
                if (bank_en[r]) bank_q[r] <= bank_d;
            end
`ifdef SHARED_REG_ARB_LOCK_EN
            state_q  <= state_d;
            owner_q  <= owner_d;
`endif
        end
    end

    assign rvalid_o = rvalid_q;
    assign rdata_o  = rdata_q;
`ifdef SHARED_REG_ARB_LOCK_EN
    assign dbg_lock_state_o = state_q;
    assign dbg_owner_o      = owner_q;
`endif

    for (genvar r = 0; r < REG_NUM; r++) begin : g_reg_out
        assign reg_o[r*DATA_WIDTH +: DATA_WIDTH] = bank_q[r];
    end
endmodule

// File: doc/shared_reg_arb.md
# shared_reg_arb

Round-robin arbiter and sequencer for a shared bank of configuration registers built from the common enable-flop primitives. Up to `REQ_NUM` requesters (bus slave ports, DMA, debug) issue single-beat read/write accesses. The arbiter grants at most one access per cycle, commits writes into the bank and returns read data one cycle later. The full bank is exposed in parallel to the IP core.

## Interface
- `REQ_NUM`, default 4: number of requesters, 2..16.
- `DATA_WIDTH`, default 32: register width.
- `ADDR_WIDTH`, default 3: register index width; bank depth `REG_NUM = 2**ADDR_WIDTH`.
- `clk_i`  in  1: clock; the only clock.
- `rst_n_i`  in  1: asynchronous active-low reset.
- `req_i`  in  REQ_NUM: per-requester access request; held until granted.
- `we_i`  in  REQ_NUM: 1 = write, 0 = read; qualified by `req_i`.
- `addr_i`  in  REQ_NUM*ADDR_WIDTH: packed register index; requester k at `[k*ADDR_WIDTH +: ADDR_WIDTH]`.
- `wdata_i`  in  REQ_NUM*DATA_WIDTH: packed write data, same packing.
- `gnt_o`  out  REQ_NUM: one-hot-or-zero grant, combinational, same cycle as the accepted request.
- `rvalid_o`  out  REQ_NUM: read response valid; one-cycle pulse to the owning requester.
- `rdata_o`  out  DATA_WIDTH: read data, valid while any `rvalid_o` bit is high.
- `reg_o`  out  REG_NUM*DATA_WIDTH: parallel image of the whole bank.

## Operation
- Arbitration pointer `ptr` (`$clog2(REQ_NUM)` bits). Winner = first requester with `req_i` high, searching upward from `ptr` with modulo wrap.
- `gnt_o[winner]` is asserted in the same cycle. An access is accepted when `req_i[k] & gnt_o[k]`.
- On acceptance, `ptr` becomes `(winner+1) mod REQ_NUM` (wrap from `REQ_NUM-1` to 0). With no request, `ptr` holds.
- Accepted write: `bank[addr] <= wdata` at the same clock edge. The bank uses enable flops, one enable per register, decoded from the accepted address.
- Accepted read: `rdata_o` is loaded with `bank[addr]` at the edge. `rvalid_o[winner]` pulses for the following cycle.
- Read of a register written in the same cycle is impossible: one access per cycle.
- Read in the cycle after a write to the same address returns the new value.
- Back-to-back accesses are accepted every cycle. With all requesters active, each is granted once every `REQ_NUM` cycles.
- Requester outputs are sampled only when granted. `we_i`, `addr_i` and `wdata_i` from non-granted requesters are ignored.

## Timing
- Reset values: `gnt_o` follows inputs combinationally (0 when `req_i` = 0). `rvalid_o` = 0, `rdata_o` = 0, `ptr` = 0, every bank register = 0, so `reg_o` = 0.
- Write latency: `reg_o` reflects the write 1 cycle after acceptance.
- Read latency: `rvalid_o`/`rdata_o` are valid 1 cycle after acceptance and last 1 cycle. `rdata_o` holds its last value otherwise.
- Throughput: 1 access/cycle.
- Reset asserted mid-operation: all state clears immediately (asynchronous). A pending `rvalid_o` is dropped. Requesters must re-issue.
- Combinational path `req_i` -> `gnt_o` only. No path from `addr_i`/`wdata_i` to outputs without a flop.

## Configuration
- Macro `SHARED_REG_ARB_LOCK_EN`.
- When defined:
  - Adds input `lock_i` (REQ_NUM) and a lock state: `UNLOCKED`, plus `LOCKED` with owner index.
  - An accepted access with `lock_i[k]`=1 moves the state to `LOCKED`, owner = k.
  - While `LOCKED`, only the owner can be granted and `ptr` does not advance.
  - An owner access with `lock_i[k]`=0 returns the state to `UNLOCKED`, and `ptr` = owner+1.
  - Reset clears the lock.
- When undefined: no `lock_i` port, no lock state; pure round-robin as above.

## Test plan
- Reset, then write req0 addr 2 data 0xDEADBEEF -> `gnt_o`=0001 same cycle; `reg_o` slot 2 = 0xDEADBEEF next cycle; all other slots 0.
- Read req1 addr 2 after the previous write -> `rvalid_o`=0010 one cycle later, `rdata_o`=0xDEADBEEF, pulse width 1.
- All 4 requesters hold `req_i` for 8 cycles -> grant order 0,1,2,3,0,1,2,3; each `gnt_o` one-hot.
- `ptr`=3, only req3 and req0 active -> req3 granted, then req0 (wrap). `ptr` ends at 1.
- Read accepted, reset pulsed before the response cycle -> `rvalid_o` stays 0, `rdata_o`=0, `reg_o`=0.
- With `SHARED_REG_ARB_LOCK_EN`: req2 locks, then req0/req1/req2 all request for 3 cycles -> only req2 is granted until its unlocking access. The next grant goes to req3 if requesting, else req0.
